// File: rtl/prover_fold_v_if.sv
// Request/response bundle for the sumcheck layer-input folder.
// The caller drives the master side, the folder the slave side.
interface prover_fold_v_if #(
  parameter int ninputs = 8,
  parameter int F_NBITS = 61
);
  localparam int lenbits = $clog2(ninputs) + 1;

  logic               en;
  logic               restart;
  logic [F_NBITS-1:0] tau;
  logic [F_NBITS-1:0] m_tau_p1;
  logic [F_NBITS-1:0] v_in [ninputs];
  logic               ready;
  logic               ready_pulse;
  logic [F_NBITS-1:0] v_pair [ninputs/2][2];
  logic [F_NBITS-1:0] v_final;
  logic [lenbits-1:0] cur_len;

  modport master (
    output en, restart, tau, m_tau_p1, v_in,
    input  ready, ready_pulse, v_pair, v_final, cur_len
  );

  modport slave (
    input  en, restart, tau, m_tau_p1, v_in,
    output ready, ready_pulse, v_pair, v_final, cur_len
  );
endinterface

// File: rtl/prover_fold_v.sv
// In-place folder: V'[i] = V[2i]*(1-tau) + V[2i+1]*tau mod F_Q,
// one element per cycle through a single shared multiply pair.
module prover_fold_v #(
  parameter int                 ninputs = 8,
  parameter int                 lenbits = $clog2(ninputs) + 1,
  parameter int                 F_NBITS = 61,
  parameter logic [F_NBITS-1:0] F_Q     = '1
) (
  input logic            clk,
  input logic            rstb,
  prover_fold_v_if.slave bus
);
  localparam int IW = lenbits - 1;
  localparam int NP = ninputs / 2;
  localparam int W2 = 2 * F_NBITS;

  typedef logic [F_NBITS-1:0] fe_t;
  typedef enum logic {S_IDLE, S_FOLD} state_e;

  state_e             state_q, state_d;
  fe_t                v_q [ninputs];
  fe_t                v_d [ninputs];
  logic [lenbits-1:0] len_q, len_d;
  logic [IW-1:0]      idx_q, idx_d;
  fe_t                tau_q, tau_d;
  fe_t                m_q, m_d;
  logic               pulse_q, pulse_d;

  fe_t                lo, hi, res;
  logic [lenbits-1:0] half_m1;
  logic               last;

  function automatic fe_t mulmod(fe_t a, fe_t b);
    logic [W2-1:0] p;
    p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    p = p % {{F_NBITS{1'b0}}, F_Q};
    return p[F_NBITS-1:0];
  endfunction

  function automatic fe_t addmod(fe_t a, fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q})
      s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  // Pair (2i, 2i+1) is read before slot i is rewritten, since i <= 2i.
  always_comb begin
    lo = '0;
    hi = '0;
    for (int j = 0; j < NP; j++) begin
      if (idx_q == IW'(j)) begin
        lo = v_q[2*j];
        hi = v_q[2*j+1];
      end
    end
    res     = addmod(mulmod(lo, m_q), mulmod(hi, tau_q));
    half_m1 = (len_q >> 1) - lenbits'(1);
    last    = ({1'b0, idx_q} == half_m1);
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tau_d   = tau_q;
    m_d     = m_q;
    pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.restart) begin
          v_d     = bus.v_in;
          len_d   = lenbits'(ninputs);
          pulse_d = 1'b1;
        end else if (bus.en) begin
          if (len_q >= lenbits'(2)) begin
            tau_d   = bus.tau;
            m_d     = bus.m_tau_p1;
            idx_d   = '0;
            state_d = S_FOLD;
          end else begin
            pulse_d = 1'b1;
          end
        end
      end
      S_FOLD: begin
        for (int j = 0; j < NP; j++) begin
          if (idx_q == IW'(j))
            v_d[j] = res;
        end
        idx_d = idx_q + IW'(1);
        if (last) begin
          len_d   = len_q >> 1;
          state_d = S_IDLE;
          pulse_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= S_IDLE;
      for (int j = 0; j < ninputs; j++)
        v_q[j] <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      tau_q   <= '0;
      m_q     <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int j = 0; j < ninputs; j++)
        v_q[j] <= v_d[j];
      len_q   <= len_d;
      idx_q   <= idx_d;
      tau_q   <= tau_d;
      m_q     <= m_d;
      pulse_q <= pulse_d;
    end
  end

  // Entries at or beyond the live length read as zero.
  always_comb begin
    for (int j = 0; j < NP; j++) begin
      for (int b = 0; b < 2; b++) begin
        if (lenbits'(2*j+b) < len_q)
          bus.v_pair[j][b] = v_q[2*j+b];
        else
          bus.v_pair[j][b] = '0;
      end
    end
  end

  assign bus.ready       = (state_q == S_IDLE);
  assign bus.ready_pulse = pulse_q;
  assign bus.v_final     = v_q[0];
  assign bus.cur_len     = len_q;

endmodule

// File: tb/tb_prover_fold_v.sv
// Bench for prover_fold_v: array-level fold model checked every cycle,
// plus literal pins and a two-entry instance for the modular wrap.
module tb_prover_fold_v;
  localparam int N  = 8;
  localparam int FB = 61;
  typedef logic [FB-1:0] fe_t;
  localparam fe_t Q = '1;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  prover_fold_v_if #(.ninputs(N), .F_NBITS(FB)) bus ();
  prover_fold_v_if #(.ninputs(2), .F_NBITS(FB)) bus2 ();

  prover_fold_v #(.ninputs(N), .F_NBITS(FB)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  prover_fold_v #(.ninputs(2), .F_NBITS(FB)) dut2 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus2)
  );

  int  checks = 0;
  int  errors = 0;
  fe_t m_v [N];
  int  m_len;
  bit  exp_ready, exp_pulse, mon_on;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic fe_t fold1(fe_t a, fe_t b, fe_t t, fe_t m);
    logic [127:0] x;
    x = (128'(a) * 128'(m) + 128'(b) * 128'(t)) % 128'(Q);
    return fe_t'(x);
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      chk("ready", 128'(bus.ready), 128'(exp_ready));
      chk("ready_pulse", 128'(bus.ready_pulse), 128'(exp_pulse));
      if (exp_ready) begin
        chk("cur_len", 128'(bus.cur_len), 128'(m_len));
        chk("v_final", 128'(bus.v_final), 128'(m_v[0]));
        for (int j = 0; j < N/2; j++)
          for (int b = 0; b < 2; b++)
            chk($sformatf("v_pair[%0d][%0d]", j, b),
                128'(bus.v_pair[j][b]),
                (2*j+b < m_len) ? 128'(m_v[2*j+b]) : 128'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle; returns in its pulse cycle.
  task automatic req(bit r, bit e, fe_t t, fe_t m, fe_t vin [N], bit poke);
    fe_t nv [N];
    int  nlen, lat;
    nv   = m_v;
    nlen = m_len;
    lat  = 1;
    bus.restart  = r;
    bus.en       = e;
    bus.tau      = t;
    bus.m_tau_p1 = m;
    bus.v_in     = vin;
    if (r) begin
      nv   = vin;
      nlen = N;
    end else if (e && m_len >= 2) begin
      for (int i = 0; i < m_len/2; i++)
        nv[i] = fold1(m_v[2*i], m_v[2*i+1], t, m);
      nlen = m_len / 2;
      lat  = m_len / 2 + 1;
    end
    tick();
    bus.restart  = 1'b0;
    bus.en       = 1'b0;
    bus.tau      = fe_t'(7);
    bus.m_tau_p1 = fe_t'(9);
    for (int k = 1; k < lat; k++) begin
      exp_ready = 1'b0;
      exp_pulse = 1'b0;
      bus.en      = poke && (k == 2);
      bus.restart = poke && (k == 2);
      tick();
    end
    bus.en      = 1'b0;
    bus.restart = 1'b0;
    exp_ready   = 1'b1;
    exp_pulse   = 1'b1;
    m_v         = nv;
    m_len       = nlen;
  endtask

  task automatic idle();
    tick();
    exp_pulse = 1'b0;
  endtask

  fe_t vinc [N];
  fe_t vw   [N];
  fe_t vz   [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      vinc[i] = fe_t'(i + 1);
      vw[i]   = fe_t'(i + 3);
      vz[i]   = '0;
    end
    vw[0] = Q - 1;
    vw[1] = Q - 1;
    bus.en = 0; bus.restart = 0; bus.tau = 0; bus.m_tau_p1 = 0; bus.v_in = vz;
    bus2.en = 0; bus2.restart = 0; bus2.tau = 0; bus2.m_tau_p1 = 0;
    bus2.v_in[0] = 0; bus2.v_in[1] = 0;
    mon_on = 0;
    m_v = vz; m_len = 0; exp_ready = 1; exp_pulse = 0;
    tick();
    tick();
    rstb = 1'b0;
    mon_on = 1'b1;
    chk("rst_len", 128'(bus.cur_len), 128'(0));
    chk("rst_ready", 128'(bus.ready), 128'(1));

    // basic fold
    req(1, 0, 0, 0, vinc, 0);
    idle();
    req(0, 1, fe_t'(2), Q - 1, vz, 0);
    chk("basic_v0", 128'(bus.v_pair[0][0]), 128'(3));
    chk("basic_v1", 128'(bus.v_pair[0][1]), 128'(5));
    chk("basic_v2", 128'(bus.v_pair[1][0]), 128'(7));
    chk("basic_v3", 128'(bus.v_pair[1][1]), 128'(9));
    chk("basic_len", 128'(bus.cur_len), 128'(4));
    idle();

    // chained folds down to the final claim
    req(0, 1, fe_t'(2), Q - 1, vz, 0);
    chk("chain_v0", 128'(bus.v_pair[0][0]), 128'(7));
    chk("chain_v1", 128'(bus.v_pair[0][1]), 128'(11));
    idle();
    req(0, 1, fe_t'(2), Q - 1, vz, 0);
    chk("chain_final", 128'(bus.v_final), 128'(15));
    chk("chain_len", 128'(bus.cur_len), 128'(1));
    idle();
    req(0, 1, fe_t'(2), Q - 1, vz, 0);
    chk("len1_final", 128'(bus.v_final), 128'(15));
    idle();

    // selection by tau
    req(1, 0, 0, 0, vinc, 0);
    idle();
    req(0, 1, fe_t'(0), fe_t'(1), vz, 0);
    chk("sel0_v3", 128'(bus.v_pair[1][1]), 128'(7));
    idle();
    req(1, 0, 0, 0, vinc, 0);
    idle();
    req(0, 1, fe_t'(1), fe_t'(0), vz, 0);
    chk("sel1_v0", 128'(bus.v_pair[0][0]), 128'(2));
    chk("sel1_v3", 128'(bus.v_pair[1][1]), 128'(8));
    idle();

    // wrap through the modulus on the wide instance
    req(1, 0, 0, 0, vw, 0);
    idle();
    req(0, 1, fe_t'(2), Q - 1, vz, 0);
    chk("wrap8_v0", 128'(bus.v_pair[0][0]), 128'(Q - 1));
    idle();

    // en+restart together, then back-to-back fold with busy pokes
    req(1, 1, fe_t'(2), Q - 1, vinc, 0);
    req(0, 1, fe_t'(2), Q - 1, vz, 1);
    chk("b2b_v1", 128'(bus.v_pair[0][1]), 128'(5));
    idle();
    tick();

    // reset asserted in cycle 2 of a fold
    req(1, 0, 0, 0, vinc, 0);
    idle();
    bus.en = 1; bus.tau = fe_t'(2); bus.m_tau_p1 = Q - 1;
    tick();
    bus.en = 0;
    exp_ready = 0; exp_pulse = 0;
    tick();
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    m_v = vz; m_len = 0; exp_ready = 1; exp_pulse = 0;
    chk("rstmid_len", 128'(bus.cur_len), 128'(0));
    chk("rstmid_ready", 128'(bus.ready), 128'(1));
    chk("rstmid_pulse", 128'(bus.ready_pulse), 128'(0));
    chk("rstmid_vp", 128'(bus.v_pair[0][1]), 128'(0));
    tick();
    req(1, 0, 0, 0, vinc, 0);
    idle();
    tick();

    // two-entry instance: modular wrap to the final claim
    bus2.v_in[0] = Q - 1;
    bus2.v_in[1] = Q - 1;
    bus2.restart = 1;
    tick();
    bus2.restart = 0;
    chk("n2_load_pulse", 128'(bus2.ready_pulse), 128'(1));
    chk("n2_load_len", 128'(bus2.cur_len), 128'(2));
    tick();
    bus2.en = 1; bus2.tau = fe_t'(2); bus2.m_tau_p1 = Q - 1;
    tick();
    bus2.en = 0; bus2.tau = 0; bus2.m_tau_p1 = 0;
    chk("n2_busy", 128'(bus2.ready), 128'(0));
    tick();
    chk("n2_ready", 128'(bus2.ready), 128'(1));
    chk("n2_pulse", 128'(bus2.ready_pulse), 128'(1));
    chk("n2_final", 128'(bus2.v_final), 128'(Q - 1));
    chk("n2_len", 128'(bus2.cur_len), 128'(1));
    tick();
    chk("n2_pulse_end", 128'(bus2.ready_pulse), 128'(0));

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
